sync_fifo: RTL and testbench

//  Single-clock synchronous FIFO; the storage end of the push/pop interface driven by the producer/consumer bench.

---
 rtl/sync_fifo_if.sv | 38 +++
 rtl/sync_fifo.sv | 105 ++++++++++
 tb/tb_sync_fifo.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: push/pop bus between a producer/consumer and the sync_fifo storage.
//   master : drives push, pop, data_in; observes data_out, flags, count and pointers
//   slave  : the FIFO side (sync_fifo)
// Optional feature macro SYNC_FIFO_ERR_FLAGS_EN adds the sticky overflow/underflow flags.
interface sync_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
    logic [ADDR_WIDTH:0]   fifo_counter;
    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif

    modport master (
        output push, pop, data_in,
        input  data_out, empty, full, fifo_counter, head, tail
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , input overflow, underflow
`endif
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, empty, full, fifo_counter, head, tail
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , output overflow, underflow
`endif
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of 2**ADDR_WIDTH entries with registered read data, no bypass.
// Ports:
//   clk    : clock, all state on posedge
//   rst_n  : asynchronous active-low reset (pointers, count, data_out, error flags)
//   bus    : sync_fifo_if.slave -- push/pop/data_in in; data_out, empty, full,
//            fifo_counter, head (read ptr), tail (write ptr) out
// Optional: define SYNC_FIFO_ERR_FLAGS_EN for sticky overflow (push dropped while full) and
// underflow (pop on empty) flags, cleared only by reset.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input logic       clk,
    input logic       rst_n,
    sync_fifo_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthCount = (ADDR_WIDTH + 1)'(Depth);

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [ADDR_WIDTH-1:0] head_q, head_d;
    logic [ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  empty, full;
    logic                  push_ok, pop_ok;

    // Flags decode the count register only, so they move on clock edges/reset alone.
    assign empty = (count_q == '0);
    assign full  = (count_q == DepthCount);

    // A pop frees a slot in the same cycle, so push is accepted on full if pop succeeds.
    assign pop_ok  = bus.pop & ~empty;
    assign push_ok = bus.push & (~full | pop_ok);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        if (pop_ok) begin
            data_out_d = mem_q[head_q];
            head_d     = head_q + 1'b1;
        end
        if (push_ok) begin
            tail_d = tail_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is not reset; writes are blocked while in reset so X inputs cannot land.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem_q[tail_q] <= bus.data_in;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q | (bus.push & full & ~bus.pop);
        underflow_d = underflow_q | (bus.pop & empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

    assign bus.data_out     = data_out_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.fifo_counter = count_q;
    assign bus.head         = head_q;
    assign bus.tail         = tail_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo (16 x 8 default configuration).
module tb_sync_fifo;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus; inputs change and outputs are sampled 1ns after the edge.
    task automatic step(input logic p, input logic q, input logic [7:0] d);
        bus.push    = p;
        bus.pop     = q;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.push    = 1'b1;
        bus.pop     = 1'b0;
        bus.data_in = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.empty !== 1'b1) begin
            bad++; $display("FAIL reset_empty got=%b want=1", bus.empty);
        end
        total++;
        if (bus.full !== 1'b0) begin
            bad++; $display("FAIL reset_full got=%b want=0", bus.full);
        end
        total++;
        if (bus.fifo_counter !== 5'd0) begin
            bad++; $display("FAIL reset_count got=%0d want=0", bus.fifo_counter);
        end
        total++;
        if (bus.head !== 4'd0 || bus.tail !== 4'd0) begin
            bad++; $display("FAIL reset_ptrs got=%0d/%0d want=0/0", bus.head, bus.tail);
        end
        total++;
        if (bus.data_out !== 8'h00) begin
            bad++; $display("FAIL reset_data got=%h want=00", bus.data_out);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        total++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            bad++; $display("FAIL reset_errflags got=%b%b want=00", bus.overflow, bus.underflow);
        end
`endif
        bus.push = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_push_pop();
        step(1'b1, 1'b0, 8'hA5);
        step(1'b1, 1'b0, 8'h3C);
        total++;
        if (bus.fifo_counter !== 5'd2 || bus.data_out !== 8'h00) begin
            bad++; $display("FAIL pp_after_push got=cnt%0d/%h want=cnt2/00",
                            bus.fifo_counter, bus.data_out);
        end
        step(1'b0, 1'b1, 8'h00);
        total++;
        if (bus.data_out !== 8'hA5) begin
            bad++; $display("FAIL pp_pop1 got=%h want=a5", bus.data_out);
        end
        step(1'b0, 1'b1, 8'h00);
        total++;
        if (bus.data_out !== 8'h3C) begin
            bad++; $display("FAIL pp_pop2 got=%h want=3c", bus.data_out);
        end
        total++;
        if (bus.empty !== 1'b1 || bus.fifo_counter !== 5'd0) begin
            bad++; $display("FAIL pp_empty got=e%b/cnt%0d want=e1/cnt0",
                            bus.empty, bus.fifo_counter);
        end
        total++;
        if (bus.head !== 4'd2 || bus.tail !== 4'd2) begin
            bad++; $display("FAIL pp_ptrs got=%0d/%0d want=2/2", bus.head, bus.tail);
        end
    endtask

    // Fills with 0x10..0x1F from a clean reset.
    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(8'h10 + i));
            if (i == 14) begin
                total++;
                if (bus.full !== 1'b0 || bus.fifo_counter !== 5'd15) begin
                    bad++; $display("FAIL fill_15 got=f%b/cnt%0d want=f0/cnt15",
                                    bus.full, bus.fifo_counter);
                end
            end
        end
        total++;
        if (bus.full !== 1'b1 || bus.fifo_counter !== 5'd16 || bus.tail !== 4'd0) begin
            bad++; $display("FAIL fill_full got=f%b/cnt%0d/tail%0d want=f1/cnt16/tail0",
                            bus.full, bus.fifo_counter, bus.tail);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        total++;
        if (bus.overflow !== 1'b0) begin
            bad++; $display("FAIL fill_ovf_early got=%b want=0", bus.overflow);
        end
`endif
        step(1'b1, 1'b0, 8'hEE);
        total++;
        if (bus.fifo_counter !== 5'd16 || bus.tail !== 4'd0 || bus.head !== 4'd0) begin
            bad++; $display("FAIL fill_17th got=cnt%0d/h%0d/t%0d want=cnt16/h0/t0",
                            bus.fifo_counter, bus.head, bus.tail);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        total++;
        if (bus.overflow !== 1'b1) begin
            bad++; $display("FAIL fill_ovf got=%b want=1", bus.overflow);
        end
`endif
    endtask

    // Starts from the full FIFO left by test_fill_overflow.
    task automatic test_full_push_pop();
        logic [7:0] exp;
        step(1'b1, 1'b1, 8'h77);
        total++;
        if (bus.data_out !== 8'h10) begin
            bad++; $display("FAIL fpp_data got=%h want=10", bus.data_out);
        end
        total++;
        if (bus.fifo_counter !== 5'd16 || bus.head !== 4'd1 || bus.tail !== 4'd1) begin
            bad++; $display("FAIL fpp_state got=cnt%0d/h%0d/t%0d want=cnt16/h1/t1",
                            bus.fifo_counter, bus.head, bus.tail);
        end
        for (int i = 0; i < 16; i++) begin
            exp = (i == 15) ? 8'h77 : 8'(8'h11 + i);
            step(1'b0, 1'b1, 8'h00);
            total++;
            if (bus.data_out !== exp) begin
                bad++; $display("FAIL fpp_drain%0d got=%h want=%h", i, bus.data_out, exp);
            end
        end
        total++;
        if (bus.empty !== 1'b1 || bus.fifo_counter !== 5'd0) begin
            bad++; $display("FAIL fpp_empty got=e%b/cnt%0d want=e1/cnt0",
                            bus.empty, bus.fifo_counter);
        end
    endtask

    // Starts empty with data_out = 0x77.
    task automatic test_empty_push_pop();
        step(1'b1, 1'b1, 8'h99);
        total++;
        if (bus.fifo_counter !== 5'd1 || bus.empty !== 1'b0) begin
            bad++; $display("FAIL epp_state got=cnt%0d/e%b want=cnt1/e0",
                            bus.fifo_counter, bus.empty);
        end
        total++;
        if (bus.data_out !== 8'h77) begin
            bad++; $display("FAIL epp_nobypass got=%h want=77", bus.data_out);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        total++;
        if (bus.underflow !== 1'b1) begin
            bad++; $display("FAIL epp_udf got=%b want=1", bus.underflow);
        end
`endif
        step(1'b0, 1'b1, 8'h00);
        total++;
        if (bus.data_out !== 8'h99 || bus.empty !== 1'b1) begin
            bad++; $display("FAIL epp_pop got=%h/e%b want=99/e1", bus.data_out, bus.empty);
        end
        // Pop on empty must leave data_out alone.
        step(1'b0, 1'b1, 8'h00);
        total++;
        if (bus.data_out !== 8'h99 || bus.fifo_counter !== 5'd0) begin
            bad++; $display("FAIL epp_popempty got=%h/cnt%0d want=99/cnt0",
                            bus.data_out, bus.fifo_counter);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'(8'h40 + i));
        end
        total++;
        if (bus.fifo_counter !== 5'd8) begin
            bad++; $display("FAIL ar_fill got=%0d want=8", bus.fifo_counter);
        end
        #2;
        bus.push    = 1'b1;
        bus.data_in = 8'hxx;
        rst_n       = 1'b0;
        #1;
        total++;
        if (bus.fifo_counter !== 5'd0 || bus.empty !== 1'b1) begin
            bad++; $display("FAIL ar_count got=cnt%0d/e%b want=cnt0/e1",
                            bus.fifo_counter, bus.empty);
        end
        total++;
        if (bus.head !== 4'd0 || bus.tail !== 4'd0 || bus.data_out !== 8'h00) begin
            bad++; $display("FAIL ar_ptrs got=h%0d/t%0d/%h want=h0/t0/00",
                            bus.head, bus.tail, bus.data_out);
        end
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.data_in = 8'h00;
        rst_n       = 1'b1;
        step(1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b1, 8'h00);
        total++;
        if (bus.data_out !== 8'h5A || bus.empty !== 1'b1) begin
            bad++; $display("FAIL ar_after got=%h/e%b want=5a/e1", bus.data_out, bus.empty);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = 8'h00;
        #2;
        test_reset();
        test_push_pop();
        test_fill_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
